// File: rtl/uart_frame_tx.sv
// uart_frame_tx
// -------------
// Serialises one score frame (board ID followed by 24-bit points, MSB byte
// first) onto a UART TX line, 8N1, LSB first within each byte. Bytes follow
// one another with no idle gap. Each frame is bracketed by a send/busy/done
// handshake toward game control.
//
// Compile-time option:
//   UART_FRAME_CHECKSUM_EN - when defined, a fifth byte is appended. It is the
//                            XOR of the four payload bytes as sent.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per UART bit (2..65535)
//   FRAME_BYTES  - payload bytes per frame (fixed at 4)
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   send     in   frame request, sampled only while idle
//   board_ID in   [7:0]  board identifier, captured on accepted send
//   points   in   [23:0] score, captured on accepted send
//   tx       out  UART serial line, idle high (registered)
//   busy     out  high while a frame is in flight (registered)
//   done     out  one-cycle pulse in the first idle cycle after a frame
//   byte_idx out  [2:0] index of the byte currently on the line (debug)
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_BYTES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [7:0]  board_ID,
    input  logic [23:0] points,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [2:0]  byte_idx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES);
`else
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_reg, state_next;
    logic [BW-1:0]  baud_reg, baud_next;
    logic [2:0]     bit_reg, bit_next;
    logic [7:0]     shift_reg, shift_next;
    logic [2:0]     byte_idx_reg, byte_idx_next;
    logic [7:0]     id_reg, id_next;
    logic [23:0]    pts_reg, pts_next;
    logic           tx_reg, tx_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;

    // Byte idx of the frame built from an ID/points pair. An ID of zero marks
    // an unassigned board; every payload byte then goes out as 8'hFF.
    function automatic logic [7:0] frame_byte(input logic [7:0]  id,
                                              input logic [23:0] pts,
                                              input logic [2:0]  idx);
        logic [7:0] b0, b1, b2, b3, r;
        b0 = (id == 8'h00) ? 8'hFF : id;
        b1 = (id == 8'h00) ? 8'hFF : pts[23:16];
        b2 = (id == 8'h00) ? 8'hFF : pts[15:8];
        b3 = (id == 8'h00) ? 8'hFF : pts[7:0];
        case (idx)
            3'd0:    r = b0;
            3'd1:    r = b1;
            3'd2:    r = b2;
            3'd3:    r = b3;
`ifdef UART_FRAME_CHECKSUM_EN
            default: r = b0 ^ b1 ^ b2 ^ b3;
`else
            default: r = 8'hFF;
`endif
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            byte_idx_reg <= '0;
            id_reg       <= '0;
            pts_reg      <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            byte_idx_reg <= byte_idx_next;
            id_reg       <= id_next;
            pts_reg      <= pts_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        byte_idx_next = byte_idx_reg;
        id_next       = id_reg;
        pts_next      = pts_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (send) begin
                    id_next       = board_ID;
                    pts_next      = points;
                    // First byte comes straight from the inputs so the start
                    // bit can go out on the very next cycle.
                    shift_next    = frame_byte(board_ID, points, 3'd0);
                    byte_idx_next = 3'd0;
                    baud_next     = '0;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            DATA: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            STOP: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next = '0;
                    if (byte_idx_reg < LAST_IDX) begin
                        byte_idx_next = byte_idx_reg + 3'd1;
                        shift_next    = frame_byte(id_reg, pts_reg, byte_idx_reg + 3'd1);
                        state_next    = START;
                    end else begin
                        byte_idx_next = 3'd0;
                        done_next     = 1'b1;
                        state_next    = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the next state, then registered. This keeps
        // tx glitch-free with no combinational path from the inputs.
        busy_next = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx       = tx_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign byte_idx = byte_idx_reg;

endmodule
